// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//
// Register-hazard scoreboard for the 5-stage pipeline. It counts in-flight
// writers per architectural register and, separately, in-flight loads whose
// data is not yet on a bypass path. Decode is held off when:
//   - a used source waits on such a load; or
//   - the destination's writer count is already saturated.
// ALU-to-ALU dependencies are left to the EX bypass mux.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   issue_valid/ready     decode handshake; a transfer fires on valid & ready
//   issue_rs/rt(_used)    source indices and their "actually read" flags
//   issue_wr_en/wr_reg    destination write enable and index
//   issue_is_load         instruction is a load (meaningful with wr_en)
//   ld_data_valid/ld_reg  load data for ld_reg reached a bypass path
//   wb_valid/wb_reg       writeback retires a write to wb_reg
//   busy_vec              per-register "writer in flight" flags
//   stall_cnt             saturating count of stalled-issue cycles
//   sb_err                sticky counter underflow / overflow flag

module reg_scoreboard #(
    parameter int NREG   = 8,
    parameter int CNTW   = 2,
    parameter int STALLW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_rs,
    input  logic [2:0]        issue_rt,
    input  logic              issue_rs_used,
    input  logic              issue_rt_used,
    input  logic              issue_wr_en,
    input  logic [2:0]        issue_wr_reg,
    input  logic              issue_is_load,
    input  logic              ld_data_valid,
    input  logic [2:0]        ld_reg,
    input  logic              wb_valid,
    input  logic [2:0]        wb_reg,
    output logic [NREG-1:0]   busy_vec,
    output logic [STALLW-1:0] stall_cnt,
    output logic              sb_err
);

    localparam int IDXW = 3;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] pend_cnt [NREG];
    logic [CNTW-1:0] ld_pend  [NREG];
    // Next count in [CNTW-1:0], error flag in [CNTW].
    logic [CNTW:0]   pend_step [NREG];
    logic [CNTW:0]   ld_step   [NREG];
    logic            err_nxt;
    logic            fire;
    logic            rs_blk;
    logic            rt_blk;
    logic            wr_blk;

    // Saturating up/down step. Opposite events cancel; stepping past either
    // end holds the count and raises the error bit.
    function automatic logic [CNTW:0] cnt_step(input logic [CNTW-1:0] cnt,
                                               input logic inc,
                                               input logic dec);
        logic [CNTW:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == CNT_MAX) res[CNTW] = 1'b1;
            else                res[CNTW-1:0] = cnt + CNTW'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) res[CNTW] = 1'b1;
            else           res[CNTW-1:0] = cnt - CNTW'(1);
        end
        return res;
    endfunction

    // A load still blocks unless its data arrives this very cycle, which
    // gives the same-cycle unblock.
    function automatic logic ld_blocks(input logic [CNTW-1:0] cnt,
                                       input logic credit);
        return cnt > CNTW'(credit);
    endfunction

    function automatic logic [STALLW-1:0] stall_sat(input logic [STALLW-1:0] v);
        return (v == '1) ? v : v + STALLW'(1);
    endfunction

    // Writer saturation ignores a same-cycle writeback: the freed slot is
    // only visible one cycle later, keeping wb off the ready path.
    always_comb begin
        rs_blk = issue_rs_used && ld_blocks(ld_pend[issue_rs],
                                            ld_data_valid && (ld_reg == issue_rs));
        rt_blk = issue_rt_used && ld_blocks(ld_pend[issue_rt],
                                            ld_data_valid && (ld_reg == issue_rt));
        wr_blk = issue_wr_en && (pend_cnt[issue_wr_reg] == CNT_MAX);
        issue_ready = !(rs_blk || rt_blk || wr_blk);
    end

    assign fire = issue_valid && issue_ready;

    always_comb begin
        err_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            pend_step[r] = cnt_step(pend_cnt[r],
                                    fire && issue_wr_en && (issue_wr_reg == IDXW'(r)),
                                    wb_valid && (wb_reg == IDXW'(r)));
            ld_step[r]   = cnt_step(ld_pend[r],
                                    fire && issue_wr_en && issue_is_load &&
                                    (issue_wr_reg == IDXW'(r)),
                                    ld_data_valid && (ld_reg == IDXW'(r)));
            err_nxt = err_nxt | pend_step[r][CNTW] | ld_step[r][CNTW];
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = |pend_cnt[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend_cnt[r] <= '0;
                ld_pend[r]  <= '0;
            end
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_cnt[r] <= pend_step[r][CNTW-1:0];
                ld_pend[r]  <= ld_step[r][CNTW-1:0];
            end
            if (issue_valid && !issue_ready) stall_cnt <= stall_sat(stall_cnt);
            sb_err <= sb_err | err_nxt;
        end
    end

endmodule
